// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-index map, bus-select codes and widths
// Common to the hardwired control unit and the datapath register bank.
package cpu_pkg;

  localparam int WIDTH  = 16;
  localparam int AWIDTH = 12;
  localparam int OWIDTH = 8;
  localparam int NREG   = 8;

  localparam int AR_IDX   = 0;
  localparam int PC_IDX   = 1;
  localparam int DR_IDX   = 2;
  localparam int AC_IDX   = 3;
  localparam int IR_IDX   = 4;
  localparam int TR_IDX   = 5;
  localparam int OUTR_IDX = 6;
  localparam int INPR_IDX = 7;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_e;

endpackage

// File: rtl/reg_bank_if.sv
// rtl/reg_bank_if.sv - strobe/bus bundle between control unit and register bank
// master = control unit side, slave = reg_bank.
interface reg_bank_if
  import cpu_pkg::*;
#(
  parameter int WIDTH  = cpu_pkg::WIDTH,
  parameter int AWIDTH = cpu_pkg::AWIDTH,
  parameter int OWIDTH = cpu_pkg::OWIDTH
);

  logic [NREG-1:0]   ld;
  logic [NREG-1:0]   inr;
  logic [NREG-1:0]   clr;
  logic [2:0]        bus_sel;
  logic [WIDTH-1:0]  mem_rdata;
  logic [WIDTH-1:0]  ac_din;
  logic [OWIDTH-1:0] inpr_din;

  logic [WIDTH-1:0]  bus;
  logic [AWIDTH-1:0] ar_out;
  logic [WIDTH-1:0]  ir_out;
  logic [WIDTH-1:0]  ac_out;
  logic [WIDTH-1:0]  dr_out;
  logic [OWIDTH-1:0] outr_out;
  logic [OWIDTH-1:0] inpr_out;
  logic              conflict;

  modport master (
    output ld, inr, clr, bus_sel, mem_rdata, ac_din, inpr_din,
    input  bus, ar_out, ir_out, ac_out, dr_out, outr_out, inpr_out, conflict
  );

  modport slave (
    input  ld, inr, clr, bus_sel, mem_rdata, ac_din, inpr_din,
    output bus, ar_out, ir_out, ac_out, dr_out, outr_out, inpr_out, conflict
  );

endinterface

// File: rtl/ctrl_reg.sv
// rtl/ctrl_reg.sv - one architectural register with clr > ld > inr > hold
// Increment wraps modulo 2^W.
module ctrl_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic         inr,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (ld) begin
      val_d = din;
    end else if (inr) begin
      val_d = val_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - eight-register datapath bank driving the common bus
// Optional sticky strobe-conflict flag: define REG_BANK_CONFLICT_EN.
module reg_bank
  import cpu_pkg::*;
#(
  parameter int WIDTH  = cpu_pkg::WIDTH,
  parameter int AWIDTH = cpu_pkg::AWIDTH,
  parameter int OWIDTH = cpu_pkg::OWIDTH
) (
  input  logic       clk,
  input  logic       reset,
  reg_bank_if.slave  bif
);

  logic [AWIDTH-1:0] ar_q;
  logic [AWIDTH-1:0] pc_q;
  logic [WIDTH-1:0]  dr_q;
  logic [WIDTH-1:0]  ac_q;
  logic [WIDTH-1:0]  ir_q;
  logic [WIDTH-1:0]  tr_q;
  logic [OWIDTH-1:0] outr_q;
  logic [OWIDTH-1:0] inpr_q;
  logic [WIDTH-1:0]  bus_d;

  // Loads sample the pre-edge bus, so a source loading itself simply holds.
  always_comb begin
    bus_d = '0;
    case (bif.bus_sel)
      BUS_NONE: bus_d = '0;
      BUS_AR:   bus_d = {{(WIDTH-AWIDTH){1'b0}}, ar_q};
      BUS_PC:   bus_d = {{(WIDTH-AWIDTH){1'b0}}, pc_q};
      BUS_DR:   bus_d = dr_q;
      BUS_AC:   bus_d = ac_q;
      BUS_IR:   bus_d = ir_q;
      BUS_TR:   bus_d = tr_q;
      BUS_MEM:  bus_d = bif.mem_rdata;
      default:  bus_d = '0;
    endcase
  end

  ctrl_reg #(.W(AWIDTH)) u_ar (
    .clk(clk), .rst_n(reset),
    .clr(bif.clr[AR_IDX]), .ld(bif.ld[AR_IDX]), .inr(bif.inr[AR_IDX]),
    .din(bus_d[AWIDTH-1:0]), .q(ar_q)
  );

  ctrl_reg #(.W(AWIDTH)) u_pc (
    .clk(clk), .rst_n(reset),
    .clr(bif.clr[PC_IDX]), .ld(bif.ld[PC_IDX]), .inr(bif.inr[PC_IDX]),
    .din(bus_d[AWIDTH-1:0]), .q(pc_q)
  );

  ctrl_reg #(.W(WIDTH)) u_dr (
    .clk(clk), .rst_n(reset),
    .clr(bif.clr[DR_IDX]), .ld(bif.ld[DR_IDX]), .inr(bif.inr[DR_IDX]),
    .din(bus_d), .q(dr_q)
  );

  ctrl_reg #(.W(WIDTH)) u_ac (
    .clk(clk), .rst_n(reset),
    .clr(bif.clr[AC_IDX]), .ld(bif.ld[AC_IDX]), .inr(bif.inr[AC_IDX]),
    .din(bif.ac_din), .q(ac_q)
  );

  ctrl_reg #(.W(WIDTH)) u_ir (
    .clk(clk), .rst_n(reset),
    .clr(bif.clr[IR_IDX]), .ld(bif.ld[IR_IDX]), .inr(bif.inr[IR_IDX]),
    .din(bus_d), .q(ir_q)
  );

  ctrl_reg #(.W(WIDTH)) u_tr (
    .clk(clk), .rst_n(reset),
    .clr(bif.clr[TR_IDX]), .ld(bif.ld[TR_IDX]), .inr(bif.inr[TR_IDX]),
    .din(bus_d), .q(tr_q)
  );

  ctrl_reg #(.W(OWIDTH)) u_outr (
    .clk(clk), .rst_n(reset),
    .clr(bif.clr[OUTR_IDX]), .ld(bif.ld[OUTR_IDX]), .inr(bif.inr[OUTR_IDX]),
    .din(bus_d[OWIDTH-1:0]), .q(outr_q)
  );

  ctrl_reg #(.W(OWIDTH)) u_inpr (
    .clk(clk), .rst_n(reset),
    .clr(bif.clr[INPR_IDX]), .ld(bif.ld[INPR_IDX]), .inr(bif.inr[INPR_IDX]),
    .din(bif.inpr_din), .q(inpr_q)
  );

`ifdef REG_BANK_CONFLICT_EN
  logic conflict_q;
  logic conflict_d;

  always_comb begin
    conflict_d = conflict_q |
                 (|((bif.clr & bif.ld) | (bif.clr & bif.inr) | (bif.ld & bif.inr)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign bif.conflict = conflict_q;
`else
  assign bif.conflict = 1'b0;
`endif

  assign bif.bus      = bus_d;
  assign bif.ar_out   = ar_q;
  assign bif.ir_out   = ir_q;
  assign bif.ac_out   = ac_q;
  assign bif.dr_out   = dr_q;
  assign bif.outr_out = outr_q;
  // INPR reaches the ALU directly rather than through the bus.
  assign bif.inpr_out = inpr_q;

endmodule

// File: doc/reg_bank.md
# reg_bank

Datapath register bank answering the hardwired control unit's `ld`/`inr`/`clr` strobe vectors. Holds the eight architectural registers (AR, PC, DR, AC, IR, TR, OUTR, INPR) and drives the 16-bit common bus. It exports IR back to the control unit for decode, and AR/bus to memory. All register updates are synchronous to `clk`. The bus is combinational from the select lines.

## Interface
- `WIDTH`, 16, common bus and full-register width
- `AWIDTH`, 12, width of AR and PC
- `OWIDTH`, 8, width of OUTR and INPR
---
- `clk`  in  1  system clock, rising-edge active
- `reset`  in  1  asynchronous, active-low; clears every register
- `ld`  in  8  per-register load strobe, index per package map
- `inr`  in  8  per-register increment strobe
- `clr`  in  8  per-register clear strobe
- `bus_sel`  in  3  common-bus source select
- `mem_rdata`  in  WIDTH  memory read data, bus source 7
- `ac_din`  in  WIDTH  ALU result, the only load source for AC
- `inpr_din`  in  OWIDTH  input-device byte, the only load source for INPR
- `bus`  out  WIDTH  common bus, also the memory write data
- `ar_out`  out  AWIDTH  memory address
- `ir_out`  out  WIDTH  instruction to the control unit
- `ac_out`  out  WIDTH  accumulator, feeds the ALU
- `dr_out`  out  WIDTH  data register, feeds the ALU
- `outr_out`  out  OWIDTH  output-device byte
- `conflict`  out  1  sticky strobe-conflict flag (see Configuration)

## Operation
- Register index map for `ld`/`inr`/`clr`:
  - 0 AR
  - 1 PC
  - 2 DR
  - 3 AC
  - 4 IR
  - 5 TR
  - 6 OUTR
  - 7 INPR
- Per-register priority within one cycle: `clr` > `ld` > `inr` > hold.
- Load sources:
  - AR and PC load `bus[AWIDTH-1:0]`.
  - DR, IR and TR load the full `bus`.
  - OUTR loads `bus[OWIDTH-1:0]`.
  - AC loads `ac_din`.
  - INPR loads `inpr_din`.
- Increment is modulo 2^width of the register. AR/PC wrap 0xFFF→0x000; 16-bit registers wrap 0xFFFF→0x0000; OUTR/INPR wrap 0xFF→0x00.
- `bus_sel` sources:
  - 0 constant zero
  - 1 AR
  - 2 PC
  - 3 DR
  - 4 AC
  - 5 IR
  - 6 TR
  - 7 `mem_rdata`
  - Narrower sources are zero-extended onto the bus.
- Any number of registers may update in the same cycle. A register loading from the bus while also being the bus source takes its own pre-edge value, so it holds.
- All outputs are direct register/bus values with no extra staging.

## Timing
- On `reset` low, every register goes to 0 immediately, independent of `clk`. `bus` then shows 0 for every select except 7, which shows `mem_rdata`. `conflict` goes to 0.
- Reset deassertion is synchronised externally. The first update happens on the first rising edge with `reset` high.
- Strobes sampled at edge N are visible on outputs after edge N, so latency is 1 cycle.
- `bus` is combinational from `bus_sel`, the registers and `mem_rdata`, with 0-cycle latency. The control unit must hold `bus_sel` stable across the edge on which a register loads from the bus.
- If reset asserts mid-operation, in-flight strobes are discarded. There is no partial update.

## Configuration
- Macro: `REG_BANK_CONFLICT_EN`.
- Defined: `conflict` sets on any edge where, for some index i, two or more of `clr[i]`, `ld[i]`, `inr[i]` are high. It stays set until `reset`. Priority resolution is unchanged.
- Undefined: `conflict` is tied to 0 and the detection logic is absent.

## Structure
- Shared package `cpu_pkg` holds:
  - the register index constants (AR_IDX..INPR_IDX)
  - the bus-select encodings (BUS_NONE..BUS_MEM)
  - the width defaults, common to the control unit and this block
- One sub-module, `ctrl_reg`: a parameterised-width register with async active-low reset and clr/ld/inr priority. It is instantiated eight times.
- The bus mux and the conflict logic stay in the top module.

## Test plan
- Assert reset mid-cycle with PC=0x123 → all outputs 0 immediately; `bus`=0 for `bus_sel`=2.
- `bus_sel`=7, `mem_rdata`=0xA5C3, `ld[4]`=1 → `ir_out`=0xA5C3 after one edge.
- Preload PC=0xFFF, then `inr[1]` → PC=0x000. Preload TR=0xFFFF, then `inr[5]` → TR=0x0000.
- `bus_sel`=2 with PC=0x07F, `ld[0]`=1 and `inr[1]`=1 in the same cycle → AR=0x07F and PC=0x080.
- DR=0x1234, then `clr[2]`, `ld[2]`, `inr[2]` together with `bus`=0xFFFF → DR=0x0000. `conflict`=1 when the macro is defined, 0 when it is not.
- `bus_sel`=6 with TR=0xBEEF, `ld[6]`=1 → `outr_out`=0xEF. `ac_din`=0x55AA, `ld[3]`=1 → `ac_out`=0x55AA regardless of `bus`.
